// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - opcode, ALU-op and FSM state definitions for the instruction sequencer
package instr_pkg;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_e;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational split of the instruction register into flags and fields
module instr_decoder
    import instr_pkg::*;
(
    input  logic [7:0] ir_i,
    output logic       is_mov_o,
    output logic       is_add_o,
    output logic       is_jmp_o,
    output logic       is_halt_o,
    output logic [2:0] rd_o,
    output logic [2:0] rs_o,
    output logic [5:0] offset_o,
    output logic [1:0] alu_op_o
);

    logic [1:0] opcode;

    assign opcode    = ir_i[7:6];
    assign is_mov_o  = (opcode == OP_MOV);
    assign is_add_o  = (opcode == OP_ADD);
    assign is_jmp_o  = (opcode == OP_JMP);
    assign is_halt_o = (opcode == OP_HALT);
    assign rd_o      = ir_i[5:3];
    assign rs_o      = ir_i[2:0];
    assign offset_o  = ir_i[5:0];
    assign alu_op_o  = (opcode == OP_ADD) ? ALU_ADD : ALU_PASS;

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - FETCH/DECODE/EXECUTE control FSM with run/step/halt and retire counter
module instruction_sequencer
    import instr_pkg::*;
#(
    parameter int COUNT_W   = 16,
    parameter bit START_RUN = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic [7:0]         instr,
    output logic               pc_en,
    output logic               mux_jump,
    output logic [5:0]         jump_adress,
    output logic               reg_write,
    output logic [2:0]         reg_dst,
    output logic [2:0]         reg_src,
    output logic [1:0]         alu_op,
    output logic               busy,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    state_e             state_q, state_d;
    logic [7:0]         ir_q, ir_d;
    logic [2:0]         reg_dst_q, reg_dst_d;
    logic [2:0]         reg_src_q, reg_src_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic [5:0]         jump_q, jump_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               run_latch_q, run_latch_d;
    logic               run_eff;

    logic       dec_mov, dec_add, dec_jmp, dec_halt;
    logic [2:0] dec_rd, dec_rs;
    logic [5:0] dec_offset;
    logic [1:0] dec_alu_op;

    instr_decoder u_decoder (
        .ir_i      (ir_q),
        .is_mov_o  (dec_mov),
        .is_add_o  (dec_add),
        .is_jmp_o  (dec_jmp),
        .is_halt_o (dec_halt),
        .rd_o      (dec_rd),
        .rs_o      (dec_rs),
        .offset_o  (dec_offset),
        .alu_op_o  (dec_alu_op)
    );

    // The latch only ever clears, so START_RUN=1 acts as an implicit run until run is first seen low.
    assign run_eff = run | run_latch_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        reg_dst_d   = reg_dst_q;
        reg_src_d   = reg_src_q;
        alu_op_d    = alu_op_q;
        jump_d      = jump_q;
        count_d     = count_q;
        run_latch_d = run_latch_q & run;
        case (state_q)
            ST_IDLE: begin
                if (run_eff || step) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                reg_dst_d = dec_rd;
                reg_src_d = dec_rs;
                alu_op_d  = dec_alu_op;
                jump_d    = dec_offset;
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                    // Counted on entry so the count is already updated during the EXECUTE strobe.
                    if (count_q != {COUNT_W{1'b1}})
                        count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_EXECUTE: begin
                state_d = run_eff ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            reg_dst_q   <= '0;
            reg_src_q   <= '0;
            alu_op_q    <= '0;
            jump_q      <= '0;
            count_q     <= '0;
            run_latch_q <= START_RUN;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            reg_dst_q   <= reg_dst_d;
            reg_src_q   <= reg_src_d;
            alu_op_q    <= alu_op_d;
            jump_q      <= jump_d;
            count_q     <= count_d;
            run_latch_q <= run_latch_d;
        end
    end

    assign pc_en       = (state_q == ST_EXECUTE);
    assign mux_jump    = (state_q == ST_EXECUTE) && dec_jmp;
    assign reg_write   = (state_q == ST_EXECUTE) && (dec_mov || dec_add);
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXECUTE);
    assign halted      = (state_q == ST_HALT);
    assign jump_adress = jump_q;
    assign reg_dst     = reg_dst_q;
    assign reg_src     = reg_src_q;
    assign alu_op      = alu_op_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed scoreboard bench for instruction_sequencer
module tb_instruction_sequencer;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          step;
    logic [7:0]    instr;
    logic          pc_en;
    logic          mux_jump;
    logic [5:0]    jump_adress;
    logic          reg_write;
    logic [2:0]    reg_dst;
    logic [2:0]    reg_src;
    logic [1:0]    alu_op;
    logic          busy;
    logic          halted;
    logic [CW-1:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          mux;
        logic          rw;
        logic [2:0]    dst;
        logic [2:0]    src;
        logic [1:0]    alu;
        logic [5:0]    jmp;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    instruction_sequencer #(.COUNT_W(CW), .START_RUN(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .instr       (instr),
        .pc_en       (pc_en),
        .mux_jump    (mux_jump),
        .jump_adress (jump_adress),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .reg_src     (reg_src),
        .alu_op      (alu_op),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [7:0] ir, input logic [CW-1:0] cnt);
        exp_t e;
        e.mux = (ir[7:6] == 2'b10);
        e.rw  = (ir[7:6] == 2'b00) || (ir[7:6] == 2'b01);
        e.dst = ir[5:3];
        e.src = ir[2:0];
        e.alu = (ir[7:6] == 2'b01) ? 2'b01 : 2'b00;
        e.jmp = ir[5:0];
        e.cnt = cnt;
        return e;
    endfunction

    // Every EXECUTE strobe must match the oldest expected retirement; any unexpected strobe is an error.
    always @(negedge clk) begin
        if (reg_write && !pc_en) chk("reg_write_outside_exec", 32'(reg_write), 32'd0);
        if (pc_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_pc_en", 32'(pc_en), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_mux_jump", 32'(mux_jump), 32'(e.mux));
                chk("sb_reg_write", 32'(reg_write), 32'(e.rw));
                chk("sb_reg_dst", 32'(reg_dst), 32'(e.dst));
                chk("sb_reg_src", 32'(reg_src), 32'(e.src));
                chk("sb_alu_op", 32'(alu_op), 32'(e.alu));
                chk("sb_jump_adress", 32'(jump_adress), 32'(e.jmp));
                chk("sb_instr_count", 32'(instr_count), 32'(e.cnt));
            end
        end
    end

    localparam logic [7:0] I_MOV  = 8'b00_010_011;
    localparam logic [7:0] I_JMP  = 8'b10_111110;
    localparam logic [7:0] I_ADD  = 8'b01_001_001;
    localparam logic [7:0] I_HALT = 8'hC0;

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        step  = 1'b0;
        instr = 8'h5A;
        @(posedge clk);

        // Reset held with run=1: everything stays at zero.
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("reset_outputs", {pc_en, mux_jump, reg_write, reg_dst, reg_src, alu_op,
                                  jump_adress, busy, halted}, 32'd0);
            chk("reset_count", 32'(instr_count), 32'd0);
        end
        reset = 1'b0;
        run   = 1'b0;
        instr = I_MOV;
        tick(1);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // MOV under run, immediately followed by JMP.
        run = 1'b1;
        sb.push_back(mk(I_MOV, 2'd1));
        tick(1);
        chk("mov_fetch_busy", {31'd0, busy}, 32'd1);
        chk("mov_fetch_no_pc_en", 32'(pc_en), 32'd0);
        tick(1);
        chk("mov_decode_no_pc_en", 32'(pc_en), 32'd0);
        tick(1);
        chk("mov_exec_latency", 32'(pc_en), 32'd1);
        instr = I_JMP;
        sb.push_back(mk(I_JMP, 2'd2));
        tick(1);
        chk("jmp_fetch_immediate_busy", 32'(busy), 32'd1);
        chk("jmp_fetch_immediate_no_pc_en", 32'(pc_en), 32'd0);
        tick(2);
        chk("jmp_exec", 32'(pc_en), 32'd1);
        chk("jmp_mux_jump", 32'(mux_jump), 32'd1);
        run = 1'b0;
        tick(1);
        chk("jmp_then_idle", 32'(busy), 32'd0);

        // Single step of an ADD; a second step during DECODE must be ignored.
        instr = I_ADD;
        step  = 1'b1;
        sb.push_back(mk(I_ADD, 2'd3));
        tick(1);
        step = 1'b0;
        chk("step_busy", 32'(busy), 32'd1);
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        chk("step_exec", 32'(pc_en), 32'd1);
        chk("step_alu_op", 32'(alu_op), 32'd1);
        tick(1);
        chk("step_return_idle", 32'(busy), 32'd0);
        tick(10);
        chk("step_still_idle", 32'(busy), 32'd0);
        chk("step_sb_drained", 32'(sb.size()), 32'd0);

        // HALT is sticky and ignores run/step until reset.
        instr = I_HALT;
        run   = 1'b1;
        tick(2);
        chk("halt_decode_not_halted", 32'(halted), 32'd0);
        tick(1);
        chk("halted_after_decode", 32'(halted), 32'd1);
        chk("halted_not_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            run  = i[0];
            step = ~i[0];
            tick(1);
            chk("halt_sticky", 32'(halted), 32'd1);
        end
        step  = 1'b0;
        run   = 1'b0;
        reset = 1'b1;
        tick(1);
        chk("halt_reset_clears", 32'(halted), 32'd0);
        chk("halt_reset_count", 32'(instr_count), 32'd0);
        reset = 1'b0;
        tick(1);

        // Five MOVs back to back: the 2-bit counter saturates at 3.
        instr = I_MOV;
        for (int k = 0; k < 5; k++) sb.push_back(mk(I_MOV, (k < 3) ? CW'(k + 1) : CW'(3)));
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(3);
            chk("sat_exec", 32'(pc_en), 32'd1);
            chk("sat_count", 32'(instr_count), (k < 3) ? k + 1 : 3);
        end
        run = 1'b0;
        tick(1);
        chk("sat_idle", 32'(busy), 32'd0);

        // Reset during DECODE aborts the instruction: no strobe afterwards.
        run = 1'b1;
        tick(2);
        chk("abort_in_decode_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        run   = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_count", 32'(instr_count), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
